// File: rtl/spi_pkg.sv
// Shared types and widths for the host-side SPI master controller.
package spi_pkg;

    localparam int SPI_CMD_W  = 10;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } spi_mst_state_e;

    function automatic logic op_is_read(input spi_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises a 10-bit command into one SS_n frame and captures the RD_DATA reply.
// Optional frame counters are built when SPI_MASTER_STATS_EN is defined.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SPI_CMD_W-1:0]  cmd_data,
    output logic                  rsp_valid,
    output logic [SPI_DATA_W-1:0] rsp_data,
    output logic                  done,
    output logic                  busy,
`ifdef SPI_MASTER_STATS_EN
    output logic [15:0]           wr_frames,
    output logic [15:0]           rd_frames,
`endif
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam logic [3:0] SEND_LAST = 4'd9;
    localparam logic [3:0] RECV_LAST = 4'd7;
    localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

    spi_mst_state_e        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [SPI_CMD_W-1:0]  tx_q, tx_d;
    spi_op_e               op_q, op_d;
    logic [SPI_DATA_W-1:0] rx_q, rx_d;
    logic [SPI_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  ss_n_q, ss_n_d;
    logic                  mosi_q, mosi_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  accept;
`ifdef SPI_MASTER_STATS_EN
    logic [15:0]           wr_frames_q, wr_frames_d;
    logic [15:0]           rd_frames_q, rd_frames_d;
`endif

    assign accept = (state_q == ST_IDLE) && cmd_valid && ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            op_q        <= WR_ADDR;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_MASTER_STATS_EN
            wr_frames_q <= '0;
            rd_frames_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            op_q        <= op_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef SPI_MASTER_STATS_EN
            wr_frames_q <= wr_frames_d;
            rd_frames_q <= rd_frames_d;
`endif
        end
    end

    // Every counted state leaves on its terminal count and hands the next state a zeroed counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_CTRL;
            ST_CTRL: begin
                state_d = ST_SEND;
                cnt_d   = '0;
            end
            ST_SEND: begin
                if (cnt_q == SEND_LAST) begin
                    cnt_d   = '0;
                    state_d = (op_q == RD_DATA) ? ST_WAIT : ST_GAP;
                end else cnt_d = cnt_q + 4'd1;
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end else cnt_d = cnt_q + 4'd1;
            end
            ST_RECV: begin
                if (cnt_q == RECV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else cnt_d = cnt_q + 4'd1;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else cnt_d = cnt_q + 4'd1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so the registered pins line up with it.
    always_comb begin
        tx_d        = tx_q;
        op_d        = op_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        mosi_d      = 1'b0;
        ss_n_d      = !(state_d inside {ST_CTRL, ST_SEND, ST_WAIT, ST_RECV});
        ready_d     = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_GAP) && (state_q != ST_GAP);
        rsp_valid_d = (state_q == ST_RECV) && (state_d == ST_GAP);
        if (accept) begin
            tx_d   = cmd_data;
            op_d   = spi_op_e'(cmd_data[9:8]);
            mosi_d = cmd_data[9];
        end
        if (state_d == ST_SEND) begin
            mosi_d = tx_q[SPI_CMD_W-1];
            tx_d   = {tx_q[SPI_CMD_W-2:0], 1'b0};
        end
        if (state_q == ST_RECV) begin
            rx_d = {rx_q[SPI_DATA_W-2:0], MISO};
            if (rsp_valid_d) rsp_data_d = rx_d;
        end
`ifdef SPI_MASTER_STATS_EN
        wr_frames_d = wr_frames_q;
        rd_frames_d = rd_frames_q;
        if (done_d) begin
            if (op_is_read(op_q)) begin
                if (rd_frames_q != 16'hFFFF) rd_frames_d = rd_frames_q + 16'd1;
            end else begin
                if (wr_frames_q != 16'hFFFF) wr_frames_d = wr_frames_q + 16'd1;
            end
        end
`endif
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
`ifdef SPI_MASTER_STATS_EN
    assign wr_frames = wr_frames_q;
    assign rd_frames = rd_frames_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave/RAM model on the far side.
module tb_spi_master_ctrl;

    localparam int L = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;
`ifdef SPI_MASTER_STATS_EN
    logic [15:0] wr_frames;
    logic [15:0] rd_frames;
`endif

    int checks = 0;
    int errors = 0;

    spi_master_ctrl #(.RD_LATENCY(L), .IDLE_GAP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .busy      (busy),
`ifdef SPI_MASTER_STATS_EN
        .wr_frames (wr_frames),
        .rd_frames (rd_frames),
`endif
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    // Slave model: collects the 11 MOSI bits of a frame, acts on the opcode, and drives the read reply.
    logic [7:0]  mem [256];
    logic [7:0]  saddr = 8'h00;
    logic [7:0]  reply = 8'h00;
    logic [10:0] sbits = '0;
    logic [1:0]  sop = 2'b00;
    int lowcnt = 0, last_len = 0, cyc = 0;
    logic [10:0] last_bits = '0;
    int done_cnt = 0, rsp_cnt = 0, done_cyc = 0;
    logic [7:0] last_rsp = 8'h00;
    logic rsp_with_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!SS_n) begin
            lowcnt++;
            if (lowcnt <= 11) sbits = {sbits[9:0], MOSI};
            if (lowcnt == 11) begin
                sop = sbits[9:8];
                case (sop)
                    2'b00: saddr = sbits[7:0];
                    2'b01: mem[saddr] = sbits[7:0];
                    2'b10: saddr = sbits[7:0];
                    default: reply = mem[saddr];
                endcase
            end
            if (sop == 2'b11 && lowcnt >= 12 + L && lowcnt <= 19 + L)
                MISO = reply[19 + L - lowcnt];
            else
                MISO = 1'b0;
        end else begin
            if (lowcnt != 0) begin
                last_len  = lowcnt;
                last_bits = sbits;
            end
            lowcnt = 0;
            MISO   = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            rsp_with_done = rsp_valid;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            last_rsp = rsp_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic send_cmd(input logic [9:0] d);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [9:0] d, input int exp_len);
        send_cmd(d);
        wait_done();
        tick();
        chk({tag, "_len"}, last_len, exp_len);
        chk({tag, "_bits"}, {21'd0, last_bits}, {21'd0, d[9], d});
        $display("frame %s cmd=%03h len=%0d bits=%03h", tag, d, last_len, last_bits);
    endtask

    initial begin
        int d0, r0, c0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        tick();
        tick();
        chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // WR_ADDR 0x0A5: control bit 0 then 0,0,1,0,1,0,0,1,0,1
        send_cmd(10'h0A5);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("t1_ss_low", {31'd0, SS_n}, 32'd0);
        wait_done();
        chk("t1_done_ss", {31'd0, SS_n}, 32'd1);
        tick();
        chk("t1_len", last_len, 11);
        chk("t1_bits", {21'd0, last_bits}, 32'h0A5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_no_rsp", rsp_cnt, 0);
        $display("frame t1 len=%0d bits=%03h done_cnt=%0d", last_len, last_bits, done_cnt);

        // WR_DATA 0x13C then RD_ADDR 0x2A5 with cmd_valid held: next accept IDLE_GAP cycles after done
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = 10'h13C;
        tick();
        cmd_data  = 10'h2A5;
        wait_done();
        c0 = cyc;
        begin
            int n = 0;
            while (cmd_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t2_gap", cyc - c0, G);
        chk("t2_first_len", last_len, 11);
        chk("t2_first_bits", {21'd0, last_bits}, 32'h13C);
        tick();
        cmd_valid = 1'b0;
        chk("t2_second_busy", {31'd0, busy}, 32'd1);
        wait_done();
        tick();
        chk("t2_second_len", last_len, 11);
        chk("t2_second_bits", {21'd0, last_bits}, 32'h6A5);
        $display("frame t2 second bits=%03h gap=%0d", last_bits, G);

        // Slave address is now 0xA5; store 0xC3 there and read it back
        run_frame("t3_wr", 10'h1C3, 11);
        r0 = rsp_cnt;
        send_cmd(10'h300);
        wait_done();
        chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_rsp_data", {24'd0, rsp_data}, 32'hC3);
        tick();
        chk("t3_len", last_len, 21);
        chk("t3_rsp_cnt", rsp_cnt - r0, 1);
        chk("t3_rsp_with_done", {31'd0, rsp_with_done}, 32'd1);
        tick();
        tick();
        chk("t3_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("t3_rsp_hold", {24'd0, rsp_data}, 32'hC3);
        $display("frame t3 len=%0d rsp=%02h", last_len, last_rsp);

        // cmd_data changes mid-frame while cmd_valid stays high
        wait_ready();
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_data  = 10'h055;
        tick();
        cmd_data  = 10'h3FF;
        tick();
        chk("t4_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        wait_done();
        cmd_valid = 1'b0;
        tick();
        chk("t4_bits", {21'd0, last_bits}, 32'h055);
        tick();
        tick();
        tick();
        chk("t4_one_done", done_cnt - d0, 1);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        $display("frame t4 bits=%03h dones=%0d", last_bits, done_cnt - d0);

        // Reset during bit 5 of an RD_DATA frame
        d0 = done_cnt;
        r0 = rsp_cnt;
        send_cmd(10'h300);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk("t5_ss_async", {31'd0, SS_n}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_rsp", rsp_cnt - r0, 0);
        chk("t5_rsp_cleared", {24'd0, rsp_data}, 32'h00);
        $display("frame t5 reset mid-frame dones=%0d rsps=%0d", done_cnt - d0, rsp_cnt - r0);
        run_frame("t5_next", 10'h0A5, 11);

        // Full loop through the slave RAM after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_frame("t6_wra", 10'h010, 11);
        run_frame("t6_wrd", 10'h15A, 11);
        run_frame("t6_rda", 10'h210, 11);
        run_frame("t6_rdd", 10'h300, 21);
        chk("t6_rsp_data", {24'd0, rsp_data}, 32'h5A);
`ifdef SPI_MASTER_STATS_EN
        chk("t6_wr_frames", {16'd0, wr_frames}, 32'd2);
        chk("t6_rd_frames", {16'd0, rd_frames}, 32'd2);
`endif
        $display("frame t6 rsp=%02h", rsp_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
